// File: rtl/skeleton_filt_multi.sv
// -----------------------------------------------------------------------------
// skeleton_filt_multi
//
// Multi-channel first-order IIR low-pass filter, y += (x - y) * 2^-SHIFT.
// A trigger snapshots all NUM_CH input samples into a buffer. The design then
// processes one channel per enabled clock. Each result is presented on a
// shared output port together with its channel index.
//
// Optional feature (compile-time macro):
//   SKELETON_FILT_MULTI_ROUND_EN : round half up on the shift term
//                                  (default: floor / arithmetic shift).
//
// Ports:
//   CLK_SYS          in   system clock, rising edge
//   RST              in   synchronous active-high reset (independent of EN)
//   EN               in   clock enable; low freezes all state and outputs
//   TRGG_START_CALC  in   start one pass over all channels (IDLE only)
//   CLR_STATE        in   zero all filter memories (IDLE only, beats trigger)
//   DATA_IN          in   NUM_CH words of BITWIDTH_SYS; sample = upper BITWIDTH_IN
//   DATA_OUT         out  filtered sample, left-aligned in BITWIDTH_SYS
//   CH_OUT           out  channel index belonging to DATA_OUT
//   DOUT_VALID       out  DATA_OUT/CH_OUT valid (one cycle per channel)
//   BUSY             out  pass in progress (CALC or DONE)
//   RDY              out  one-cycle pulse after the pass completes
//   OVERRUN          out  sticky: trigger seen while BUSY; cleared by RST only
//   DATA_HEAD        out  constant configuration descriptor
// -----------------------------------------------------------------------------
module skeleton_filt_multi #(
  parameter int BITWIDTH_IN   = 16,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int NUM_CH        = 4,
  parameter int SHIFT         = 3
) (
  input  logic                           CLK_SYS,
  input  logic                           RST,
  input  logic                           EN,
  input  logic                           TRGG_START_CALC,
  input  logic                           CLR_STATE,
  input  logic [NUM_CH*BITWIDTH_SYS-1:0] DATA_IN,
  output logic [BITWIDTH_SYS-1:0]        DATA_OUT,
  output logic [5:0]                     CH_OUT,
  output logic                           DOUT_VALID,
  output logic                           BUSY,
  output logic                           RDY,
  output logic                           OVERRUN,
  output logic [BITWIDTH_HEAD-7:0]       DATA_HEAD
);

  localparam logic [5:0] LAST_CH = 6'(NUM_CH - 1);
  localparam logic [5:0] NCH6    = 6'(NUM_CH);
  localparam logic [5:0] SHIFT6  = 6'(SHIFT);
  localparam logic [4:0] BWIN5   = 5'(BITWIDTH_IN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                         state_q, state_d;
  logic [5:0]                     cnt_q, cnt_d;
  logic signed [BITWIDTH_IN-1:0]  x_buf_q [NUM_CH];
  logic signed [BITWIDTH_IN-1:0]  y_q     [NUM_CH];
  logic [BITWIDTH_SYS-1:0]        dout_q;
  logic [5:0]                     ch_q;
  logic                           valid_q, rdy_q, ovr_q;

  // Control strobes from the FSM; they take effect only on enabled edges.
  logic start, clr, calc, ovr_set;

  // Datapath for the channel selected by cnt_q.
  logic signed [BITWIDTH_IN-1:0]  x_sel, y_sel, y_new;
  logic signed [BITWIDTH_IN:0]    diff;
  logic signed [BITWIDTH_IN+1:0]  diff_ext, term_wide;
  logic [BITWIDTH_IN+BITWIDTH_SYS-1:0] dout_wide;

`ifdef SKELETON_FILT_MULTI_ROUND_EN
  // One extra bit of headroom so adding the half-LSB cannot overflow.
  localparam logic signed [BITWIDTH_IN+1:0] HALF = (BITWIDTH_IN+2)'(1) <<< (SHIFT - 1);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    clr     = 1'b0;
    calc    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (CLR_STATE) begin
          clr = 1'b1;                 // clear wins, trigger is dropped
        end else if (TRGG_START_CALC) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        calc    = 1'b1;
        ovr_set = TRGG_START_CALC;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == LAST_CH) state_d = DONE;
      end
      DONE: begin
        ovr_set = TRGG_START_CALC;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel select and filter arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cnt_q == 6'(k)) begin
        x_sel = x_buf_q[k];
        y_sel = y_q[k];
      end
    end
  end

  always_comb begin
    diff     = (BITWIDTH_IN+1)'(x_sel) - (BITWIDTH_IN+1)'(y_sel);
    diff_ext = (BITWIDTH_IN+2)'(diff);
`ifdef SKELETON_FILT_MULTI_ROUND_EN
    term_wide = (diff_ext + HALF) >>> SHIFT;
`else
    term_wide = diff_ext >>> SHIFT;
`endif
    // Result wraps to BITWIDTH_IN bits.
    y_new     = y_sel + term_wide[BITWIDTH_IN-1:0];
    // Left-align the sample; the low BITWIDTH_SYS-BITWIDTH_IN bits stay zero.
    dout_wide = {y_new, {BITWIDTH_SYS{1'b0}}};
  end

  // ---------------------------------------------------------------------------
  // FSM, counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (EN) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= calc;
      rdy_q   <= (state_q == DONE);
      ovr_q   <= ovr_q | ovr_set;
      if (calc) begin
        dout_q <= dout_wide[BITWIDTH_IN+BITWIDTH_SYS-1 -: BITWIDTH_SYS];
        ch_q   <= cnt_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel input buffer and filter memory
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    always_ff @(posedge CLK_SYS) begin
      if (RST) begin
        x_buf_q[gi] <= '0;
        y_q[gi]     <= '0;
      end else if (EN) begin
        if (start)
          x_buf_q[gi] <= DATA_IN[gi*BITWIDTH_SYS + BITWIDTH_SYS - 1 -: BITWIDTH_IN];
        if (clr)
          y_q[gi] <= '0;
        else if (calc && (cnt_q == 6'(gi)))
          y_q[gi] <= y_new;
      end
    end
  end

  assign DATA_OUT   = dout_q;
  assign CH_OUT     = ch_q;
  assign DOUT_VALID = valid_q;
  assign BUSY       = (state_q != IDLE);
  assign RDY        = rdy_q;
  assign OVERRUN    = ovr_q;
  assign DATA_HEAD  = {4'd6, NCH6, SHIFT6, BWIN5, BWIN5};

endmodule

// File: tb/tb_skeleton_filt_multi.sv
module tb_skeleton_filt_multi;

  localparam int NCH = 4;

  logic        CLK_SYS = 1'b0;
  logic        RST, EN, TRGG_START_CALC, CLR_STATE;
  logic [63:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic [5:0]  CH_OUT;
  logic        DOUT_VALID, BUSY, RDY, OVERRUN;
  logic [25:0] DATA_HEAD;

`ifdef SKELETON_FILT_MULTI_ROUND_EN
  localparam logic [15:0] RND7 = 16'd1;
`else
  localparam logic [15:0] RND7 = 16'd0;
`endif

  skeleton_filt_multi #(
    .BITWIDTH_IN(16), .BITWIDTH_SYS(16), .BITWIDTH_HEAD(32), .NUM_CH(4), .SHIFT(3)
  ) dut (
    .CLK_SYS(CLK_SYS), .RST(RST), .EN(EN), .TRGG_START_CALC(TRGG_START_CALC),
    .CLR_STATE(CLR_STATE), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .CH_OUT(CH_OUT),
    .DOUT_VALID(DOUT_VALID), .BUSY(BUSY), .RDY(RDY), .OVERRUN(OVERRUN),
    .DATA_HEAD(DATA_HEAD)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          vld_cnt = 0;
  logic [21:0] exp_q[$];
  logic        en_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic push4(input logic [15:0] v0, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [15:0] v3);
    exp_q.push_back({6'd0, v0});
    exp_q.push_back({6'd1, v1});
    exp_q.push_back({6'd2, v2});
    exp_q.push_back({6'd3, v3});
  endtask

  // EN as seen by the DUT at the most recent rising edge; a valid output is a
  // new transaction only if that edge was enabled (otherwise it is frozen).
  always @(posedge CLK_SYS) en_seen = EN;

  // Scoreboard monitor
  always @(negedge CLK_SYS) begin
    if (en_seen && DOUT_VALID) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got ch %0d data %h, expected no output", CH_OUT, DATA_OUT);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        $display("out ch=%0d data=%h expected ch=%0d data=%h", CH_OUT, DATA_OUT, e[21:16], e[15:0]);
        check("dout", {10'd0, CH_OUT, DATA_OUT}, {10'd0, e});
      end
    end
  end

  task automatic do_clear();
    CLR_STATE = 1'b1;
    tick();
    CLR_STATE = 1'b0;
  endtask

  // Runs one pass; trig_at injects a trigger before edge E(trig_at),
  // EN is held low for en_off_len edges starting at E(en_off_at).
  task automatic run_pass(input string tag, input int exp_lat, input int trig_at,
                          input int en_off_at, input int en_off_len, input logic [63:0] din);
    int got;
    int v0;
    got = -1;
    v0  = vld_cnt;
    DATA_IN = din;
    TRGG_START_CALC = 1'b1;
    tick();                               // E0
    TRGG_START_CALC = 1'b0;
    DATA_IN = {$urandom, $urandom};       // must not affect the running pass
    check({tag, "_busy_start"}, {31'd0, BUSY}, 32'd1);
    for (int i = 1; i <= 40 && got < 0; i++) begin
      TRGG_START_CALC = (i == trig_at);
      EN = !(en_off_len > 0 && i >= en_off_at && i < en_off_at + en_off_len);
      tick();
      if (RDY) got = i;
    end
    TRGG_START_CALC = 1'b0;
    EN = 1'b1;
    check({tag, "_rdy_latency"}, got, exp_lat);
    check({tag, "_busy_at_rdy"}, {31'd0, BUSY}, 32'd0);
    tick();
    check({tag, "_rdy_one_cycle"}, {31'd0, RDY}, 32'd0);
    check({tag, "_valid_count"}, vld_cnt - v0, NCH);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    $display("pass %s done, rdy after %0d edges", tag, got);
  endtask

  initial begin
    int rdy_seen;
    int v0;
    RST = 1'b1; EN = 1'b0; TRGG_START_CALC = 1'b0; CLR_STATE = 1'b0;
    DATA_IN = {$urandom, $urandom};
    repeat (3) tick();
    check("rst_data_out", {16'd0, DATA_OUT}, 0);
    check("rst_ch_out", {26'd0, CH_OUT}, 0);
    check("rst_valid", {31'd0, DOUT_VALID}, 0);
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_rdy", {31'd0, RDY}, 0);
    check("rst_overrun", {31'd0, OVERRUN}, 0);
    check("data_head", {6'd0, DATA_HEAD}, {6'd0, 4'd6, 6'd4, 6'd3, 5'd16, 5'd16});
    RST = 1'b0; EN = 1'b1;
    tick();

    // Step response
    push4(16'd256, 16'd256, 16'd256, 16'd256);
    run_pass("step1", 5, 0, 0, 0, {4{16'h0800}});
    push4(16'd480, 16'd480, 16'd480, 16'd480);
    run_pass("step2", 5, 0, 0, 0, {4{16'h0800}});

    // Clear with simultaneous trigger: no pass, state zeroed
    CLR_STATE = 1'b1; TRGG_START_CALC = 1'b1; DATA_IN = {4{16'h0800}};
    tick();
    CLR_STATE = 1'b0; TRGG_START_CALC = 1'b0;
    check("clr_no_busy", {31'd0, BUSY}, 0);
    check("clr_no_overrun", {31'd0, OVERRUN}, 0);
    tick();
    check("clr_still_idle", {31'd0, BUSY}, 0);
    push4(16'd256, 16'd256, 16'd256, 16'd256);
    run_pass("after_clr", 5, 0, 0, 0, {4{16'h0800}});

    // Negative input on channel 2
    do_clear();
    push4(16'h0000, 16'h0000, 16'hFF00, 16'h0000);
    run_pass("neg", 5, 0, 0, 0, {16'h0000, 16'hF800, 16'h0000, 16'h0000});

    // Rounding of a small step
    do_clear();
    push4(RND7, RND7, RND7, RND7);
    run_pass("round", 5, 0, 0, 0, {4{16'h0007}});

    // Trigger while busy
    do_clear();
    check("ovr_before", {31'd0, OVERRUN}, 0);
    push4(16'd256, 16'd256, 16'd256, 16'd256);
    run_pass("overrun", 5, 2, 0, 0, {4{16'h0800}});
    check("ovr_after", {31'd0, OVERRUN}, 1);

    // EN low for 3 cycles mid-pass
    push4(16'd480, 16'd480, 16'd480, 16'd480);
    run_pass("en_hold", 8, 0, 2, 3, {4{16'h0800}});
    check("ovr_sticky", {31'd0, OVERRUN}, 1);

    // Reset at E2 of a pass: only channel 0 (2048-480)/8+480 = 676 emerges
    v0 = vld_cnt;
    exp_q.push_back({6'd0, 16'd676});
    DATA_IN = {4{16'h0800}};
    TRGG_START_CALC = 1'b1;
    tick();                               // E0
    TRGG_START_CALC = 1'b0;
    tick();                               // E1
    RST = 1'b1;
    tick();                               // E2 with reset
    check("rst_mid_data_out", {16'd0, DATA_OUT}, 0);
    check("rst_mid_ch_out", {26'd0, CH_OUT}, 0);
    check("rst_mid_valid", {31'd0, DOUT_VALID}, 0);
    check("rst_mid_busy", {31'd0, BUSY}, 0);
    check("rst_mid_rdy", {31'd0, RDY}, 0);
    check("rst_mid_overrun", {31'd0, OVERRUN}, 0);
    RST = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (RDY) rdy_seen = 1;
    end
    check("rst_mid_no_rdy", rdy_seen, 0);
    check("rst_mid_valid_count", vld_cnt - v0, 1);
    check("rst_mid_queue", exp_q.size(), 0);

    // Reset must have zeroed the filter memories
    push4(16'd256, 16'd256, 16'd256, 16'd256);
    run_pass("post_rst", 5, 0, 0, 0, {4{16'h0800}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
